// File: rtl/mul_div_unit_if.sv
// ============================================================================
//  Module   : mul_div_unit_if
//  Purpose  : Request/response bundle between an issuing stage and the
//             multiply/divide unit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mul_div_unit_if;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        busy;
    logic        done;
    logic [31:0] rd_data;
    logic [4:0]  rd_out;
    logic        RegWEn;

    modport master (
        output start, funct3, rs1_data, rs2_data, rd,
        input  busy, done, rd_data, rd_out, RegWEn
    );

    modport slave (
        input  start, funct3, rs1_data, rs2_data, rd,
        output busy, done, rd_data, rd_out, RegWEn
    );
endinterface

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
//  Module   : mul_div_unit
//  Purpose  : 32-bit iterative multiply/divide (shift-add / restoring divide),
//             one result bit per cycle, with single-cycle special cases.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_unit (
    input  wire logic     clk,
    input  wire logic     reset,
    mul_div_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [2:0]  r_op;
    logic [4:0]  r_rd;
    logic [5:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_b;
    logic        r_neg_lo;
    logic        r_neg_hi;
    logic [31:0] r_rd_data;
    logic [4:0]  r_rd_out;

    // Operand decode on the live inputs, used only at the accepting edge
    logic        w_is_div;
    logic        w_a_signed;
    logic        w_b_signed;
    logic        w_sa;
    logic        w_sb;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic        w_div_zero;
    logic        w_div_ovf;
    logic        w_special;
    logic [31:0] w_special_res;

    always_comb begin
        w_is_div      = bus.funct3[2];
        w_a_signed    = w_is_div ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
        w_b_signed    = w_is_div ? ~bus.funct3[0] : ~bus.funct3[1];
        w_sa          = w_a_signed & bus.rs1_data[31];
        w_sb          = w_b_signed & bus.rs2_data[31];
        w_mag_a       = w_sa ? (32'd0 - bus.rs1_data) : bus.rs1_data;
        w_mag_b       = w_sb ? (32'd0 - bus.rs2_data) : bus.rs2_data;
        w_div_zero    = w_is_div && (bus.rs2_data == 32'd0);
        w_div_ovf     = w_is_div && !bus.funct3[0] &&
                        (bus.rs1_data == 32'h8000_0000) && (bus.rs2_data == 32'hFFFF_FFFF);
        w_special     = w_div_zero | w_div_ovf;
        w_special_res = 32'd0;
        if (w_div_zero) begin
            w_special_res = bus.funct3[1] ? bus.rs1_data : 32'hFFFF_FFFF;
        end else if (w_div_ovf) begin
            w_special_res = bus.funct3[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // One iteration: r_hi is accumulator/remainder, r_lo multiplier/quotient
    logic [32:0] w_sum;
    logic [32:0] w_rem_sh;
    logic        w_ge;
    logic [31:0] w_hi_n;
    logic [31:0] w_lo_n;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_result;

    always_comb begin
        w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : 33'd0);
        w_rem_sh = {r_hi, r_lo[31]};
        w_ge     = (w_rem_sh >= {1'b0, r_b});
        if (r_op[2]) begin
            w_hi_n = w_ge ? (w_rem_sh[31:0] - r_b) : w_rem_sh[31:0];
            w_lo_n = {r_lo[30:0], w_ge};
        end else begin
            w_hi_n = w_sum[32:1];
            w_lo_n = {w_sum[0], r_lo[31:1]};
        end
        w_prod = r_neg_lo ? (64'd0 - {w_hi_n, w_lo_n}) : {w_hi_n, w_lo_n};
        w_quot = r_neg_lo ? (32'd0 - w_lo_n) : w_lo_n;
        w_rem  = r_neg_hi ? (32'd0 - w_hi_n) : w_hi_n;
        case (r_op)
            3'b000:                 w_result = w_prod[31:0];
            3'b001, 3'b010, 3'b011: w_result = w_prod[63:32];
            3'b100, 3'b101:         w_result = w_quot;
            default:                w_result = w_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = w_special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == 6'd31) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op      <= 3'd0;
            r_rd      <= 5'd0;
            r_cnt     <= 6'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_b       <= 32'd0;
            r_neg_lo  <= 1'b0;
            r_neg_hi  <= 1'b0;
            r_rd_data <= 32'd0;
            r_rd_out  <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op     <= bus.funct3;
                        r_rd     <= bus.rd;
                        r_cnt    <= 6'd0;
                        r_hi     <= 32'd0;
                        r_lo     <= w_is_div ? w_mag_a : w_mag_b;
                        r_b      <= w_is_div ? w_mag_b : w_mag_a;
                        r_neg_lo <= w_sa ^ w_sb;
                        r_neg_hi <= w_sa;
                        if (w_special) begin
                            r_rd_data <= w_special_res;
                            r_rd_out  <= bus.rd;
                        end
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 6'd1;
                    r_hi  <= w_hi_n;
                    r_lo  <= w_lo_n;
                    // Results publish only on entry to DONE so outputs hold between operations
                    if (r_cnt == 6'd31) begin
                        r_rd_data <= w_result;
                        r_rd_out  <= r_rd;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = (r_state == S_DONE);
    assign bus.rd_data = r_rd_data;
    assign bus.rd_out  = r_rd_out;
    assign bus.RegWEn  = (r_state == S_DONE) && (r_rd_out != 5'd0);

endmodule

`default_nettype wire

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 32 bits.
REQ-002 The block SHALL have a single clock domain; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a new operation; sampled only in IDLE.
REQ-006 funct3  input  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 rs1_data  input  32  operand A (multiplicand/dividend), as read from the register file.
REQ-008 rs2_data  input  32  operand B (multiplier/divisor).
REQ-009 rd  input  5  destination register index.
REQ-010 busy  output  1  high while an operation is in flight (state not IDLE).
REQ-011 done  output  1  one-cycle pulse; result is valid in that cycle.
REQ-012 rd_data  output  32  result to be written back.
REQ-013 rd_out  output  5  destination index captured at start.
REQ-014 RegWEn  output  1  writeback enable; equals done AND (rd_out != 0).

Function
REQ-015 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-016 IDLE + start: latch funct3, rd and both operands, then enter CALC, or enter DONE directly for a special case (REQ-022 to REQ-024).
REQ-017 CALC SHALL run exactly 32 iterations from a 6-bit counter, one bit per cycle, then enter DONE.
REQ-018 DONE SHALL last exactly one cycle: done=1, rd_data valid; then return to IDLE.
REQ-019 Latency: start sampled at edge N -> done high in cycle N+33 for the normal path, N+1 for the special path.
REQ-020 start while busy SHALL be ignored and the in-flight operation SHALL complete unaffected; inputs are don't-care except at the accepting edge.
REQ-021 Multiply: shift-add on operand magnitudes with sign fix-up of the 64-bit product.
- MUL: low 32 bits.
- MULH: high 32 bits, signed x signed.
- MULHSU: high 32 bits, signed A x unsigned B.
- MULHU: high 32 bits, unsigned x unsigned.
REQ-022 Divide: restoring division on magnitudes.
- Quotient sign = sign(A) XOR sign(B) for signed ops.
- Remainder sign = sign(A).
REQ-023 Divide by zero (B=0) SHALL take the special path: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> A.
REQ-024 Signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF) SHALL take the special path: DIV -> 0x80000000; REM -> 0.
REQ-025 Multiply SHALL never take the special path, including zero operands (these run the full 32 cycles).
REQ-026 rd=0 SHALL still complete with done=1, but RegWEn=0.
REQ-027 rd_data and rd_out SHALL hold their values after DONE until the next DONE.
REQ-028 busy SHALL be 1 in CALC and in DONE.

Reset
REQ-029 reset SHALL force IDLE and counter=0, and all outputs to 0: busy, done, RegWEn, rd_data, rd_out.
REQ-030 reset SHALL take priority over start.
REQ-031 reset asserted in CALC SHALL abort the operation with no done pulse; the next start after reset deasserts behaves as from power-up.

Verification
REQ-032 MUL A=7, B=-3 (0xFFFFFFFD), rd=5 -> done at N+33, rd_data=0xFFFFFFEB, rd_out=5, RegWEn=1, busy high in cycles N+1..N+33.
REQ-033 MULH/MULHSU/MULHU with A=0x80000000, B=0xFFFFFFFF -> 0x00000000 / 0x80000000 / 0x7FFFFFFF respectively.
REQ-034 DIV A=-7, B=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU A=100, B=7 -> 14; REMU same operands -> 2.
REQ-035 DIV A=5, B=0 -> done at N+1, rd_data=0xFFFFFFFF; REM same operands -> 5; DIV A=0x80000000, B=-1 -> 0x80000000 at N+1.
REQ-036 start pulsed again at N+10 during MUL -> ignored, single done at N+33; rd=0 operation -> done=1, RegWEn=0.
REQ-037 reset at N+15 during DIVU -> busy=0 and rd_data=0 next cycle, no done pulse; a new MUL 3x4 then yields 12 after 33 cycles.
